// File: rtl/ysyx_22050019_axi_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_22050019_axi_pkg
// Shared definitions for the IFU/LSU AXI read arbiter:
//   - default address/data widths
//   - AXI response codes
//   - read-FSM state encoding and master identifiers
//   - onehot_of(): maps a master id to its one-hot grant vector
// -----------------------------------------------------------------------------
package ysyx_22050019_axi_pkg;

  localparam int unsigned AXI_ADDR_W = 64;
  localparam int unsigned AXI_DATA_W = 64;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AR_M0 = 3'd1,
    R_M0  = 3'd2,
    AR_M1 = 3'd3,
    R_M1  = 3'd4
  } rd_state_e;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_e;

  // Bit 0 of a grant vector belongs to m0, bit 1 to m1.
  function automatic logic [1:0] onehot_of(input mst_e m);
    logic [1:0] v;
    case (m)
      MST_M0:  v = 2'b01;
      MST_M1:  v = 2'b10;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ysyx_22050019_rr_arb2.sv
// -----------------------------------------------------------------------------
// ysyx_22050019_rr_arb2
// Two-way round-robin tie-break. Purely combinational.
// Ports:
//   req_i        [1:0]  request vector (bit 0 = m0, bit 1 = m1)
//   last_grant_i        master that won the previous arbitration
//   grant_o      [1:0]  one-hot grant, all-zero when nothing is requested
// -----------------------------------------------------------------------------
module ysyx_22050019_rr_arb2
  import ysyx_22050019_axi_pkg::*;
(
  input  logic [1:0] req_i,
  input  mst_e       last_grant_i,
  output logic [1:0] grant_o
);

  // Single requester wins outright; on a tie the master not served last wins.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = onehot_of(MST_M0);
      2'b10:   grant_o = onehot_of(MST_M1);
      2'b11:   grant_o = (last_grant_i == MST_M1) ? onehot_of(MST_M0) : onehot_of(MST_M1);
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_22050019_axi_arbiter.sv
// -----------------------------------------------------------------------------
// ysyx_22050019_axi_arbiter
// Shares one AXI slave port between the IFU read master (m0) and the LSU
// read/write master (m1).
//   - Reads: one outstanding transaction at a time, arbitrated in IDLE with a
//     registered grant (one cycle of arbitration latency), round-robin on ties.
//   - Writes: m1 aw/w/b channels are wired straight through to the slave.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   m0_ar*/m0_r*                    IFU read address / read data channels
//   m1_ar*/m1_r*                    LSU read address / read data channels
//   m1_aw*/m1_w*/m1_b*              LSU write channels (pass-through)
//   s_*                             downstream slave port
// -----------------------------------------------------------------------------
module ysyx_22050019_axi_arbiter
  import ysyx_22050019_axi_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // m0: IFU read master
  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_arready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic              m0_rready,
  // m1: LSU read master
  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_arready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  input  logic              m1_rready,
  // m1: LSU write master
  input  logic              m1_awvalid,
  input  logic [ADDR_W-1:0] m1_awaddr,
  output logic              m1_awready,
  input  logic              m1_wvalid,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_wready,
  output logic              m1_bvalid,
  output logic [1:0]        m1_bresp,
  input  logic              m1_bready,
  // s: slave port
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  output logic              s_rready,
  output logic              s_awvalid,
  output logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awready,
  output logic              s_wvalid,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_wready,
  input  logic              s_bvalid,
  input  logic [1:0]        s_bresp,
  output logic              s_bready
);

  rd_state_e  state_q;
  mst_e       last_grant_q;
  logic [1:0] grant_s;

  ysyx_22050019_rr_arb2 u_rr_arb2 (
    .req_i        ({m1_arvalid, m0_arvalid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_s)
  );

  // Read FSM: grant taken in IDLE, held through AR and R phases.
  // last_grant only moves on an AR handshake, so an abandoned grant never
  // counts as a turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= MST_M0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_s[1]) begin
            state_q <= AR_M1;
          end else if (grant_s[0]) begin
            state_q <= AR_M0;
          end else begin
            state_q <= IDLE;
          end
        end
        AR_M0: begin
          if (m0_arvalid && s_arready) begin
            state_q      <= R_M0;
            last_grant_q <= MST_M0;
          end
        end
        R_M0: begin
          if (s_rvalid && m0_rready) begin
            state_q <= IDLE;
          end
        end
        AR_M1: begin
          if (m1_arvalid && s_arready) begin
            state_q      <= R_M1;
            last_grant_q <= MST_M1;
          end
        end
        R_M1: begin
          if (s_rvalid && m1_rready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Read-channel steering; everything not owned by the current phase is 0,
  // so a stray s_rvalid outside an R phase never reaches either master.
  always_comb begin
    s_arvalid  = 1'b0;
    s_araddr   = {ADDR_W{1'b0}};
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = {DATA_W{1'b0}};
    m0_rresp   = RESP_OKAY;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = {DATA_W{1'b0}};
    m1_rresp   = RESP_OKAY;
    case (state_q)
      AR_M0: begin
        s_arvalid  = m0_arvalid;
        s_araddr   = m0_araddr;
        m0_arready = s_arready;
      end
      R_M0: begin
        m0_rvalid = s_rvalid;
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        s_rready  = m0_rready;
      end
      AR_M1: begin
        s_arvalid  = m1_arvalid;
        s_araddr   = m1_araddr;
        m1_arready = s_arready;
      end
      R_M1: begin
        m1_rvalid = s_rvalid;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        s_rready  = m1_rready;
      end
      default: begin
        s_arvalid = 1'b0;
      end
    endcase
  end

  // Write path: m1 only, independent of the read FSM.
  assign s_awvalid  = m1_awvalid;
  assign s_awaddr   = m1_awaddr;
  assign m1_awready = s_awready;
  assign s_wvalid   = m1_wvalid;
  assign s_wdata    = m1_wdata;
  assign s_wstrb    = m1_wstrb;
  assign m1_wready  = s_wready;
  assign m1_bvalid  = s_bvalid;
  assign m1_bresp   = s_bresp;
  assign s_bready   = m1_bready;

endmodule

// File: tb/tb_ysyx_22050019_axi_arbiter.sv
module tb_ysyx_22050019_axi_arbiter;
  import ysyx_22050019_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [63:0] m0_araddr, m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [63:0] m1_araddr, m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [63:0] m1_awaddr, m1_wdata;
  logic [7:0]  m1_wstrb;
  logic [1:0]  m1_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [63:0] s_araddr, s_rdata;
  logic [1:0]  s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [63:0] s_awaddr, s_wdata;
  logic [7:0]  s_wstrb;
  logic [1:0]  s_bresp;

  int n_assert = 0;
  int n_fail   = 0;
  int gq[$];   // observed grant order: 0 = m0, 1 = m1

  always #5 clk = ~clk;

  ysyx_22050019_axi_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_inputs();
    m0_arvalid = 1'b0; m0_araddr = 64'h0; m0_rready = 1'b0;
    m1_arvalid = 1'b0; m1_araddr = 64'h0; m1_rready = 1'b0;
    m1_awvalid = 1'b0; m1_awaddr = 64'h0; m1_wvalid = 1'b0;
    m1_wdata = 64'h0; m1_wstrb = 8'h00; m1_bready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 64'h0; s_rresp = 2'b00;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rdata_of(input logic [63:0] a);
    return {a[31:0], ~a[31:0]} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  // Transaction-level reference: both masters block on their own read,
  // re-request the cycle after completion, and the slave answers with
  // rdata_of(addr) after a random delay. Expected owner of each read comes
  // from the round-robin rule applied to which queues are non-empty.
  task automatic run_random(input int n0, input int n1);
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] a;
    logic [63:0] exp_addr;
    logic [63:0] sdata = 64'h0;
    logic [1:0]  sresp = 2'b00;
    int ph = 0, own = 0, last = 0, dly = 0, cyc = 0;
    bit busy = 1'b0;
    gq.delete();
    for (int i = 0; i < n0; i++) begin
      a = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
      q0.push_back(a);
    end
    for (int i = 0; i < n1; i++) begin
      a = 64'h9000_0000 + 64'($urandom_range(0, 4095)) * 64'd8;
      q1.push_back(a);
    end
    while ((q0.size() != 0 || q1.size() != 0 || ph != 0) && cyc < 4000) begin
      m0_arvalid = (q0.size() != 0) && !(ph == 2 && own == 0);
      m0_araddr  = m0_arvalid ? q0[0] : 64'h0;
      m1_arvalid = (q1.size() != 0) && !(ph == 2 && own == 1);
      m1_araddr  = m1_arvalid ? q1[0] : 64'h0;
      s_arready  = ($urandom_range(0, 2) != 0);
      if (busy && dly == 0) begin
        s_rvalid = 1'b1; s_rdata = sdata; s_rresp = sresp;
      end else if (!busy && $urandom_range(0, 3) == 0) begin
        s_rvalid = 1'b1; s_rdata = 64'hDEAD; s_rresp = RESP_SLVERR;
      end else begin
        s_rvalid = 1'b0; s_rdata = {32'h0, $urandom}; s_rresp = 2'b00;
      end
      m0_rready = ($urandom_range(0, 3) != 0);
      m1_rready = ($urandom_range(0, 3) != 0);
      settle();
      case (ph)
        0: begin
          chk("rnd_idle_arvalid", s_arvalid, 1'b0);
          chk("rnd_idle_arready", {m1_arready, m0_arready}, 2'b00);
          chk("rnd_idle_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
          chk("rnd_idle_rready", s_rready, 1'b0);
          if (q0.size() != 0 || q1.size() != 0) begin
            if (q0.size() != 0 && q1.size() != 0) own = (last == 1) ? 0 : 1;
            else own = (q1.size() != 0) ? 1 : 0;
            ph = 1;
          end
        end
        1: begin
          exp_addr = (own == 1) ? q1[0] : q0[0];
          chk("rnd_ar_valid", s_arvalid, 1'b1);
          chk("rnd_ar_addr", s_araddr, exp_addr);
          chk("rnd_ar_ready_own", (own == 1) ? m1_arready : m0_arready, s_arready);
          chk("rnd_ar_ready_other", (own == 1) ? m0_arready : m1_arready, 1'b0);
          chk("rnd_ar_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
          chk("rnd_ar_rready", s_rready, 1'b0);
          if (s_arready) begin
            gq.push_back(m1_arready ? 1 : 0);
            if (own == 1) void'(q1.pop_front()); else void'(q0.pop_front());
            sdata = rdata_of(exp_addr);
            sresp = ($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY;
            dly   = $urandom_range(0, 2);
            busy  = 1'b1;
            last  = own;
            ph    = 2;
          end
        end
        default: begin
          chk("rnd_r_valid_own", (own == 1) ? m1_rvalid : m0_rvalid, s_rvalid);
          chk("rnd_r_data_own", (own == 1) ? m1_rdata : m0_rdata, s_rdata);
          chk("rnd_r_resp_own", (own == 1) ? m1_rresp : m0_rresp, s_rresp);
          chk("rnd_r_valid_other", (own == 1) ? m0_rvalid : m1_rvalid, 1'b0);
          chk("rnd_r_data_other", (own == 1) ? m0_rdata : m1_rdata, 64'h0);
          chk("rnd_r_rready", s_rready, (own == 1) ? m1_rready : m0_rready);
          chk("rnd_r_arvalid", s_arvalid, 1'b0);
          if (s_rvalid && ((own == 1) ? m1_rready : m0_rready)) begin
            busy = 1'b0;
            ph   = 0;
          end else if (dly > 0) begin
            dly--;
          end
        end
      endcase
      step();
      cyc++;
    end
    chk("rnd_drained", (q0.size() == 0 && q1.size() == 0 && ph == 0), 1'b1);
    clr_inputs();
  endtask

  initial begin
    // Reset state, with noise on the inputs
    clr_inputs();
    rst_n = 1'b0;
    m0_arvalid = 1'b1; m0_araddr = 64'h8000_0000;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 64'hFFFF;
    step();
    chk("rst_s_arvalid", s_arvalid, 1'b0);
    chk("rst_s_araddr", s_araddr, 64'h0);
    chk("rst_arready", {m1_arready, m0_arready}, 2'b00);
    chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    chk("rst_rdata", m0_rdata | m1_rdata, 64'h0);
    chk("rst_s_rready", s_rready, 1'b0);
    do_reset();

    // Single IFU read, zero-latency slave
    m0_arvalid = 1'b1; m0_araddr = 64'h8000_0000;
    settle();
    chk("ifu_latency", s_arvalid, 1'b0);
    step();
    s_arready = 1'b1;
    settle();
    chk("ifu_ar_valid", s_arvalid, 1'b1);
    chk("ifu_ar_addr", s_araddr, 64'h8000_0000);
    chk("ifu_arready", {m1_arready, m0_arready}, 2'b01);
    step();
    m0_arvalid = 1'b0; m0_araddr = 64'h0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 64'h0000_0000_0010_0073; s_rresp = RESP_OKAY; m0_rready = 1'b1;
    settle();
    chk("ifu_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
    chk("ifu_rdata", m0_rdata, 64'h0000_0000_0010_0073);
    chk("ifu_rready", s_rready, 1'b1);
    step();
    settle();
    chk("ifu_back_idle_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    chk("ifu_back_idle_rready", s_rready, 1'b0);
    clr_inputs();

    // Simultaneous requests after reset: LSU first, IFU next
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 64'h8000_0004;
    m1_arvalid = 1'b1; m1_araddr = 64'h8000_1000;
    step();
    s_arready = 1'b1;
    settle();
    chk("tie_first_addr", s_araddr, 64'h8000_1000);
    chk("tie_first_arready", {m1_arready, m0_arready}, 2'b10);
    step();
    m1_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 64'h1111; m1_rready = 1'b1;
    settle();
    chk("tie_first_rdata", m1_rdata, 64'h1111);
    chk("tie_first_rvalid", {m1_rvalid, m0_rvalid}, 2'b10);
    step();
    s_rvalid = 1'b0; m1_rready = 1'b0;
    settle();
    chk("tie_idle_gap", s_arvalid, 1'b0);
    step();
    s_arready = 1'b1;
    settle();
    chk("tie_second_addr", s_araddr, 64'h8000_0004);
    chk("tie_second_arready", {m1_arready, m0_arready}, 2'b01);
    step();
    m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 64'h2222; m0_rready = 1'b1;
    settle();
    chk("tie_second_rdata", m0_rdata, 64'h2222);
    step();
    clr_inputs();

    // Stray s_rvalid during AR_M0, then write concurrent with the read
    m0_arvalid = 1'b1; m0_araddr = 64'h8000_0100;
    step();
    s_rvalid = 1'b1; s_rdata = 64'hDEAD;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("stray_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
      chk("stray_rready", s_rready, 1'b0);
      chk("stray_rdata", m0_rdata, 64'h0);
      step();
    end
    s_rvalid = 1'b0; s_rdata = 64'h0; s_arready = 1'b1;
    m1_awvalid = 1'b1; m1_awaddr = 64'h8000_2000; m1_wvalid = 1'b1;
    m1_wdata = 64'h1122_3344_5566_7788; m1_wstrb = 8'h0F; m1_bready = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1;
    settle();
    chk("wr_awaddr", s_awaddr, 64'h8000_2000);
    chk("wr_wdata", s_wdata, 64'h1122_3344_5566_7788);
    chk("wr_wstrb", s_wstrb, 8'h0F);
    chk("wr_ready", {m1_awready, m1_wready, s_awvalid, s_wvalid}, 4'hF);
    chk("wr_read_ar", m0_arready, 1'b1);
    step();
    m0_arvalid = 1'b0; s_arready = 1'b0; m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    s_bvalid = 1'b1; s_bresp = RESP_OKAY; s_rvalid = 1'b1; s_rdata = 64'h3333; m0_rready = 1'b1;
    settle();
    chk("wr_bvalid", {m1_bvalid, s_bready}, 2'b11);
    chk("wr_bresp", m1_bresp, RESP_OKAY);
    chk("wr_read_rdata", m0_rdata, 64'h3333);
    step();
    clr_inputs();

    // Reset asserted mid-read in R_M1
    m1_arvalid = 1'b1; m1_araddr = 64'h9000_0000;
    step();
    s_arready = 1'b1;
    settle();
    chk("rstmid_ar", m1_arready, 1'b1);
    step();
    m1_arvalid = 1'b0; s_arready = 1'b0; m1_rready = 1'b1;
    settle();
    chk("rstmid_in_r", s_rready, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_rready", s_rready, 1'b0);
    chk("rstmid_arready", m1_arready, 1'b0);
    s_rvalid = 1'b1; s_rdata = 64'h4444;
    #1;
    chk("rstmid_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    step();
    clr_inputs();
    rst_n = 1'b1;
    m0_arvalid = 1'b1; m0_araddr = 64'h8000_0000;
    step();
    s_arready = 1'b1;
    settle();
    chk("rstmid_regrant_addr", s_araddr, 64'h8000_0000);
    chk("rstmid_regrant_ready", {m1_arready, m0_arready}, 2'b01);
    step();
    m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 64'h5555; m0_rready = 1'b1;
    settle();
    chk("rstmid_regrant_rdata", m0_rdata, 64'h5555);
    step();
    clr_inputs();

    // Continuous requests from both: strict alternation starting with m1
    do_reset();
    run_random(4, 4);
    chk("alt_count", gq.size(), 8);
    for (int i = 0; i < gq.size() && i < 8; i++)
      chk($sformatf("alt_grant_%0d", i), gq[i], (i % 2 == 0) ? 1 : 0);

    // Unequal loads and single-master runs
    do_reset();
    run_random(7, 3);
    do_reset();
    run_random(0, 5);
    do_reset();
    run_random(5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050019_axi_arbiter.md
YSYX_22050019_AXI_ARBITER -- requirements
Module: ysyx_22050019_axi_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 64, address width; DATA_W, 64, data width; STRB_W, DATA_W/8, byte-strobe width.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 IFU read master (m0): m0_arvalid in 1, m0_araddr in ADDR_W, m0_arready out 1, m0_rvalid out 1, m0_rdata out DATA_W, m0_rresp out 2, m0_rready in 1.
REQ-005 LSU read master (m1): m1_arvalid in 1, m1_araddr in ADDR_W, m1_arready out 1, m1_rvalid out 1, m1_rdata out DATA_W, m1_rresp out 2, m1_rready in 1.
REQ-006 LSU write master (m1): m1_awvalid/m1_awaddr/m1_wvalid/m1_wdata/m1_wstrb/m1_bready in; m1_awready/m1_wready/m1_bvalid/m1_bresp(2) out.
REQ-007 Slave port (s): s_arvalid/s_araddr/s_rready/s_awvalid/s_awaddr/s_wvalid/s_wdata/s_wstrb/s_bready out; s_arready/s_rvalid/s_rdata/s_rresp/s_awready/s_wready/s_bvalid/s_bresp in.

Function
REQ-008 Read FSM SHALL have states IDLE, AR_M0, R_M0, AR_M1, R_M1.
REQ-009 IDLE: only m1_arvalid -> AR_M1; only m0_arvalid -> AR_M0; both -> master not granted last (last_grant register); neither -> stay.
REQ-010 Grant is registered: a request first seen in IDLE at cycle N SHALL reach s_arvalid at cycle N+1 (one cycle arbitration latency).
REQ-011 AR_Mx: s_arvalid=mx_arvalid, s_araddr=mx_araddr, mx_arready=s_arready; on s_arvalid&&s_arready -> R_Mx and last_grant<=x.
REQ-012 R_Mx: mx_rvalid=s_rvalid, mx_rdata=s_rdata, mx_rresp=s_rresp, s_rready=mx_rready; on s_rvalid&&s_rready -> IDLE.
REQ-013 Non-granted master SHALL see arready=0 and rvalid=0; its arvalid is held pending, never dropped.
REQ-014 In IDLE and AR_Mx, s_rready=0 and any s_rvalid SHALL be ignored, never forwarded.
REQ-015 Exactly one read transaction outstanding; a new grant needs a return to IDLE (minimum 3 cycles per read at zero slave latency).
REQ-016 Write channels aw/w/b SHALL pass m1<->s combinationally, unarbitrated, independent of read FSM; m0 has no write port.
REQ-017 Unselected output data/address buses SHALL drive 0.
REQ-018 Masters hold arvalid/araddr stable until handshake (AXI rule); arbiter need not latch araddr.

Reset
REQ-019 rst_n low SHALL force IDLE and last_grant=M0 (LSU wins first tie) immediately, independent of clk.
REQ-020 During reset all arbiter-driven read valid/ready outputs SHALL be 0 and read address/data outputs 0.
REQ-021 Reset mid-transaction SHALL abandon it without replay; clearing slave state is the slave's responsibility.

Structure
REQ-022 Shared package ysyx_22050019_axi_pkg SHALL hold read-FSM state encoding, AXI resp codes (OKAY=2'b00, SLVERR=2'b10) and ADDR_W/DATA_W defaults.
REQ-023 Tie-break logic SHALL be sub-module ysyx_22050019_rr_arb2 (2 requests, last_grant in, one-hot grant out); rest stays flat.

Verification
REQ-024 Only m0_arvalid, araddr=0x8000_0000, slave arready/rvalid next cycle, rdata=0x0000_0000_0010_0073 -> m0 receives data, m1_rvalid never 1, FSM back in IDLE 3 cycles after request.
REQ-025 m0/m1 arvalid together after reset, addrs 0x8000_0004/0x8000_1000 -> m1 granted first, s_araddr=0x8000_1000; m0 served next with 0x8000_0004.
REQ-026 Continuous requests from both for 8 reads -> grants strictly alternate m1,m0,m1,...; neither starved.
REQ-027 s_rvalid=1 with rdata=0xDEAD while in AR_M0 (no AR handshake) -> m0_rvalid and m1_rvalid stay 0.
REQ-028 m1 write awaddr=0x8000_2000, wdata=0x1122_3344_5566_7788, wstrb=0x0F concurrent with m0 read -> both complete, s_wstrb=0x0F, m1_bresp=OKAY.
REQ-029 rst_n low in R_M1 with s_rvalid=0 -> same-cycle IDLE, m1_arready=0, m1_rvalid=0; after release m0 request at 0x8000_0000 granted normally.
